// File: rtl/adder_share_pkg.sv
// Shared constants, ID-width helper and output-stage record for the adder-sharing arbiter.
package adder_share_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_WIDTH   = 32;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    if (r < 1) r = 1;
    return r;
  endfunction

  localparam int DEF_ID_W = clog2_min1(DEF_NUM_REQ);

  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic [DEF_ID_W-1:0]  id;
    logic                 carry;
  } out_stage_t;

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  always_comb begin
    int pos;
    pos   = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = ID_W'(pos);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters, single-entry output stage.
// Optional macro ADDER_SHARE_CARRY_EN adds a registered rsp_carry output.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2_min1(NUM_REQ),
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic [ID_W-1:0]          rsp_id
`ifdef ADDER_SHARE_CARRY_EN
  ,
  output logic                     rsp_carry
`endif
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic               win_any;
  logic               can_accept;
  logic               accept;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // A drain and a load can share a cycle, so a full stage still accepts when rsp_ready is high.
  assign can_accept = !rsp_valid || rsp_ready;
  assign req_ready  = (rst_n && can_accept) ? win_grant : '0;
  assign accept     = rst_n && can_accept && win_any;

  assign op_a = req_a[int'(win_idx)*WIDTH +: WIDTH];
  assign op_b = req_b[int'(win_idx)*WIDTH +: WIDTH];

`ifdef ADDER_SHARE_CARRY_EN
  logic [WIDTH:0] sum_full;
  assign sum_full = {1'b0, op_a} + {1'b0, op_b};
`else
  logic [WIDTH-1:0] sum_full;
  assign sum_full = op_a + op_b;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
`ifdef ADDER_SHARE_CARRY_EN
      rsp_carry <= 1'b0;
`endif
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= sum_full[WIDTH-1:0];
      rsp_id    <= win_idx;
      rr_ptr    <= (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
`ifdef ADDER_SHARE_CARRY_EN
      rsp_carry <= sum_full[WIDTH];
`endif
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter with two 32-bit requesters.
module tb_adder_share_arbiter;
  import adder_share_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_sum;
  logic [0:0]  rsp_id;
  logic        got_carry;

  out_stage_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int m_ptr      = 0;
  logic m_valid  = 1'b0;

  always #5 clk = ~clk;

`ifdef ADDER_SHARE_CARRY_EN
  logic rsp_carry;
  assign got_carry = rsp_carry;
`else
  assign got_carry = 1'b0;
`endif

  adder_share_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
`ifdef ADDER_SHARE_CARRY_EN
    ,
    .rsp_carry (rsp_carry)
`endif
  );

  function automatic out_stage_t observed();
    return out_stage_t'({rsp_sum, rsp_id, got_carry});
  endfunction

  // Expected one-hot grant from the bench's own round-robin state.
  function automatic logic [1:0] model_grant();
    logic [1:0] g;
    g = 2'b00;
    if (rst_n && (!m_valid || rsp_ready)) begin
      if (req_valid[m_ptr])         g[m_ptr] = 1'b1;
      else if (req_valid[1 - m_ptr]) g[1 - m_ptr] = 1'b1;
    end
    return g;
  endfunction

  task automatic drive(input logic rst, input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic rr,
                       output logic [1:0] exp_g);
    @(negedge clk);
    rst_n     = rst;
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    rsp_ready = rr;
    #1;
    exp_g = model_grant();
    if (exp_g != 2'b00) begin
      out_stage_t e;
      logic [32:0] s;
      int idx;
      idx = exp_g[1] ? 1 : 0;
      s = {1'b0, req_a[idx*32 +: 32]} + {1'b0, req_b[idx*32 +: 32]};
      e.sum = s[31:0];
      e.id  = 1'(idx);
`ifdef ADDER_SHARE_CARRY_EN
      e.carry = s[32];
`else
      e.carry = 1'b0;
`endif
      sb.push_back(e);
      m_ptr = (idx + 1) % 2;
    end
  endtask

  task automatic tick(input logic accepted);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      sb.delete();
    end else if (accepted) begin
      m_valid = 1'b1;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    logic [1:0] g;
    drive(1'b0, 2'b00, 0, 0, 0, 0, 1'b1, g);
    tick(1'b0);
  endtask

  task automatic test_reset();
    logic [1:0] g;
    out_stage_t e;
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 2'b11, 32'd5, 32'd6, 32'd7, 32'd8, 1'b1, g);
      compared++;
      if (req_ready !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL reset_ready: got %b want 00", req_ready);
      end
      tick(1'b0);
      compared++;
      if (rsp_valid !== 1'b0 || observed() !== out_stage_t'(0)) begin
        mismatched++;
        $display("[TB] FAIL reset_state: got valid=%b sum=%h id=%0d want 0/0/0", rsp_valid, rsp_sum, rsp_id);
      end
    end
    drive(1'b1, 2'b11, 32'd5, 32'd6, 32'd7, 32'd8, 1'b1, g);
    compared++;
    if (req_ready !== g || g !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL reset_first_grant: got %b want 01", req_ready);
    end
    tick(g != 2'b00);
    e = (sb.size() > 0) ? sb.pop_front() : out_stage_t'('1);
    compared++;
    if (rsp_valid !== 1'b1 || observed() !== e) begin
      mismatched++;
      $display("[TB] FAIL reset_first_rsp: got sum=%h id=%0d want sum=%h id=%0d", rsp_sum, rsp_id, e.sum, e.id);
    end
  endtask

  task automatic test_single();
    logic [1:0] g;
    out_stage_t e;
    do_reset();
    drive(1'b1, 2'b01, 32'h10, 32'h4, 32'h0, 32'h0, 1'b1, g);
    compared++;
    if (req_ready !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL single_ready: got %b want 01", req_ready);
    end
    tick(g != 2'b00);
    e = (sb.size() > 0) ? sb.pop_front() : out_stage_t'('1);
    compared++;
    if (rsp_valid !== 1'b1 || observed() !== e || rsp_sum !== 32'h14) begin
      mismatched++;
      $display("[TB] FAIL single_rsp: got valid=%b sum=%h id=%0d want 1/%h/%0d", rsp_valid, rsp_sum, rsp_id, e.sum, e.id);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    out_stage_t e;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 2'b11, 32'd1, 32'd1, 32'd2, 32'd2, 1'b1, g);
      compared++;
      if (req_ready !== g || req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        mismatched++;
        $display("[TB] FAIL rr_ready[%0d]: got %b want %b", c, req_ready, g);
      end
      tick(g != 2'b00);
      e = (sb.size() > 0) ? sb.pop_front() : out_stage_t'('1);
      compared++;
      if (rsp_valid !== 1'b1 || observed() !== e) begin
        mismatched++;
        $display("[TB] FAIL rr_rsp[%0d]: got sum=%h id=%0d want sum=%h id=%0d", c, rsp_sum, rsp_id, e.sum, e.id);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    out_stage_t e;
    out_stage_t held;
    do_reset();
    drive(1'b1, 2'b11, 32'd1, 32'd1, 32'd2, 32'd2, 1'b1, g);
    tick(g != 2'b00);
    held = (sb.size() > 0) ? sb.pop_front() : out_stage_t'('1);
    compared++;
    if (rsp_valid !== 1'b1 || observed() !== held) begin
      mismatched++;
      $display("[TB] FAIL bp_first: got sum=%h id=%0d want sum=%h id=%0d", rsp_sum, rsp_id, held.sum, held.id);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 2'b11, 32'd1, 32'd1, 32'd2, 32'd2, 1'b0, g);
      compared++;
      if (req_ready !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL bp_stall_ready[%0d]: got %b want 00", c, req_ready);
      end
      tick(g != 2'b00);
      compared++;
      if (rsp_valid !== 1'b1 || observed() !== held) begin
        mismatched++;
        $display("[TB] FAIL bp_hold[%0d]: got sum=%h id=%0d want sum=%h id=%0d", c, rsp_sum, rsp_id, held.sum, held.id);
      end
    end
    drive(1'b1, 2'b11, 32'd1, 32'd1, 32'd2, 32'd2, 1'b1, g);
    compared++;
    if (req_ready !== g || g !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL bp_release_ready: got %b want 10", req_ready);
    end
    tick(g != 2'b00);
    e = (sb.size() > 0) ? sb.pop_front() : out_stage_t'('1);
    compared++;
    if (rsp_valid !== 1'b1 || observed() !== e) begin
      mismatched++;
      $display("[TB] FAIL bp_release_rsp: got sum=%h id=%0d want sum=%h id=%0d", rsp_sum, rsp_id, e.sum, e.id);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] g;
    out_stage_t e;
    do_reset();
    drive(1'b1, 2'b01, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 1'b1, g);
    tick(g != 2'b00);
    e = (sb.size() > 0) ? sb.pop_front() : out_stage_t'('1);
    compared++;
    if (rsp_valid !== 1'b1 || observed() !== e || rsp_sum !== 32'h1) begin
      mismatched++;
      $display("[TB] FAIL wrap_carry: got sum=%h c=%b want sum=%h c=%b", rsp_sum, got_carry, e.sum, e.carry);
    end
    drive(1'b1, 2'b10, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h1, 1'b1, g);
    tick(g != 2'b00);
    e = (sb.size() > 0) ? sb.pop_front() : out_stage_t'('1);
    compared++;
    if (rsp_valid !== 1'b1 || observed() !== e || rsp_sum !== 32'h8000_0000) begin
      mismatched++;
      $display("[TB] FAIL wrap_nocarry: got sum=%h c=%b want sum=%h c=%b", rsp_sum, got_carry, e.sum, e.carry);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [1:0] g;
    out_stage_t e;
    do_reset();
    drive(1'b1, 2'b01, 32'd1, 32'd1, 32'd2, 32'd2, 1'b1, g);
    tick(g != 2'b00);
    void'(sb.pop_front());
    drive(1'b1, 2'b11, 32'd1, 32'd1, 32'd2, 32'd2, 1'b0, g);
    tick(g != 2'b00);
    drive(1'b0, 2'b11, 32'd1, 32'd1, 32'd2, 32'd2, 1'b0, g);
    compared++;
    if (req_ready !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL midrst_ready: got %b want 00", req_ready);
    end
    tick(1'b0);
    compared++;
    if (rsp_valid !== 1'b0 || observed() !== out_stage_t'(0)) begin
      mismatched++;
      $display("[TB] FAIL midrst_state: got valid=%b sum=%h id=%0d want 0/0/0", rsp_valid, rsp_sum, rsp_id);
    end
    drive(1'b1, 2'b11, 32'd1, 32'd1, 32'd2, 32'd2, 1'b0, g);
    compared++;
    if (req_ready !== g || g !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL midrst_grant: got %b want 01", req_ready);
    end
    tick(g != 2'b00);
    e = (sb.size() > 0) ? sb.pop_front() : out_stage_t'('1);
    compared++;
    if (rsp_valid !== 1'b1 || observed() !== e) begin
      mismatched++;
      $display("[TB] FAIL midrst_rsp: got sum=%h id=%0d want sum=%h id=%0d", rsp_sum, rsp_id, e.sum, e.id);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
